countdown_timer: RTL and testbench

//  Down-counting MM:SS timer, the counterpart of the up-counting minute/second chain.

---
 rtl/countdown_timer.sv | 142 ++++++++++++++
 tb/tb_countdown_timer.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// MM:SS down-counter with one-second prescaler, pause/resume and expiry pulse.
// Define AUTO_RELOAD_EN for periodic mode (reload preset on expiry, keep running).
module countdown_timer #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [5:0] set_minute,
  input  logic [5:0] set_second,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [5:0] r_minute,
  output logic [5:0] r_second,
  output logic       sec_tick,
  output logic       running,
  output logic       expired
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  state_t          state, state_n;
  logic [PW-1:0]   presc, presc_n;
  logic [5:0]      pre_min, pre_sec;
  logic [5:0]      pre_min_n, pre_sec_n;
  logic [5:0]      min_n, sec_n;
  logic [5:0]      ld_min, ld_sec;
  logic            tick_n, exp_n;
  logic            at_zero, last_sec;

  assign ld_min   = (set_minute > 6'd59) ? 6'd59 : set_minute;
  assign ld_sec   = (set_second > 6'd59) ? 6'd59 : set_second;
  assign at_zero  = (r_minute == 6'd0) && (r_second == 6'd0);
  assign last_sec = (r_minute == 6'd0) && (r_second == 6'd1);

  always_comb begin
    state_n   = state;
    presc_n   = presc;
    min_n     = r_minute;
    sec_n     = r_second;
    pre_min_n = pre_min;
    pre_sec_n = pre_sec;
    tick_n    = 1'b0;
    exp_n     = 1'b0;
    if (clear) begin
      state_n   = IDLE;
      presc_n   = '0;
      min_n     = 6'd0;
      sec_n     = 6'd0;
      pre_min_n = 6'd0;
      pre_sec_n = 6'd0;
    end else if (load) begin
      state_n   = IDLE;
      presc_n   = '0;
      min_n     = ld_min;
      sec_n     = ld_sec;
      pre_min_n = ld_min;
      pre_sec_n = ld_sec;
    end else begin
      unique case (state)
        RUN: begin
          if (stop) state_n = PAUSE;
          if (presc == LAST) begin
            presc_n = '0;
            tick_n  = 1'b1;
            if (last_sec) begin
              exp_n = 1'b1;
`ifdef AUTO_RELOAD_EN
              min_n = pre_min;
              sec_n = pre_sec;
`else
              // Expiry wins over a coincident stop.
              min_n   = 6'd0;
              sec_n   = 6'd0;
              state_n = DONE;
`endif
            end else if (r_second != 6'd0) begin
              sec_n = r_second - 6'd1;
            end else begin
              sec_n = 6'd59;
              min_n = r_minute - 6'd1;
            end
          end else begin
            presc_n = presc + 1'b1;
          end
        end
        IDLE, PAUSE: begin
          if (start && !stop) begin
            if (at_zero) begin
              exp_n   = 1'b1;
              state_n = DONE;
            end else begin
              state_n = RUN;
            end
          end
        end
        DONE: begin
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      presc    <= '0;
      r_minute <= 6'd0;
      r_second <= 6'd0;
      pre_min  <= 6'd0;
      pre_sec  <= 6'd0;
      sec_tick <= 1'b0;
      expired  <= 1'b0;
      running  <= 1'b0;
    end else begin
      state    <= state_n;
      presc    <= presc_n;
      r_minute <= min_n;
      r_second <= sec_n;
      pre_min  <= pre_min_n;
      pre_sec  <= pre_sec_n;
      sec_tick <= tick_n;
      expired  <= exp_n;
      running  <= (state_n == RUN);
    end
  end

  a_no_zero_run: assert property (
    @(posedge clk) disable iff (!rst_n)
    (state == RUN) |-> !at_zero
  );

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized and directed bench for countdown_timer (TICK_DIV=4).
// Reference model tracks the count as total seconds and a per-second phase.
module tb_countdown_timer;

  localparam int TD = 4;
  localparam int M_IDLE = 0;
  localparam int M_RUN = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic [5:0] set_minute = 6'd0;
  logic [5:0] set_second = 6'd0;
  logic [5:0] r_minute;
  logic [5:0] r_second;
  logic       sec_tick;
  logic       running;
  logic       expired;

  int errors = 0;
  int checks = 0;

  int m_mode;
  int m_total;
  int m_preset;
  int m_phase;
  bit m_tick;
  bit m_exp;

  countdown_timer #(.TICK_DIV(TD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .set_minute (set_minute),
    .set_second (set_second),
    .start      (start),
    .stop       (stop),
    .clear      (clear),
    .r_minute   (r_minute),
    .r_second   (r_second),
    .sec_tick   (sec_tick),
    .running    (running),
    .expired    (expired)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = M_IDLE;
    m_total = 0;
    m_preset = 0;
    m_phase = 0;
    m_tick = 0;
    m_exp = 0;
  endtask

  task automatic model_step();
    int mm, ss;
    m_tick = 0;
    m_exp = 0;
    if (clear) begin
      m_mode = M_IDLE;
      m_total = 0;
      m_preset = 0;
      m_phase = 0;
    end else if (load) begin
      mm = (set_minute > 59) ? 59 : int'(set_minute);
      ss = (set_second > 59) ? 59 : int'(set_second);
      m_total = mm * 60 + ss;
      m_preset = m_total;
      m_phase = 0;
      m_mode = M_IDLE;
    end else if (m_mode == M_RUN) begin
      m_phase++;
      if (m_phase == TD) begin
        m_phase = 0;
        m_total--;
        m_tick = 1;
        if (m_total == 0) begin
          m_exp = 1;
`ifdef AUTO_RELOAD_EN
          m_total = m_preset;
`else
          m_mode = M_DONE;
`endif
        end
      end
      if (stop && m_mode != M_DONE) m_mode = M_PAUSE;
    end else if ((m_mode == M_IDLE || m_mode == M_PAUSE) && !stop && start) begin
      if (m_total == 0) begin
        m_exp = 1;
        m_mode = M_DONE;
      end else begin
        m_mode = M_RUN;
      end
    end
  endtask

  function automatic logic [14:0] expv();
    return {6'(m_total / 60), 6'(m_total % 60), m_tick, m_mode == M_RUN, m_exp};
  endfunction

  function automatic logic [14:0] obs();
    return {r_minute, r_second, sec_tick, running, expired};
  endfunction

  task automatic drive(input bit l, c, s, p, input logic [5:0] mm, ss);
    load = l;
    clear = c;
    start = s;
    stop = p;
    set_minute = mm;
    set_second = ss;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #3;
    checks++;
    if (obs() !== 15'd0) begin
      errors++;
      $display("FAIL reset_hold got=%h want=0", obs());
    end
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (obs() !== 15'd0) begin
      errors++;
      $display("FAIL reset_idle got=%h want=0", obs());
    end
  endtask

  task automatic test_basic();
    int ticks = 0;
    int exps = 0;
    int exp_at = -1;
    bit run1 = 0;
    drive(1, 0, 0, 0, 6'd0, 6'd3);
    step();
    checks++;
    if (r_second !== 6'd3 || running !== 1'b0) begin
      errors++;
      $display("FAIL basic_load got=%0d:%0d run=%b want=0:3 run=0",
               r_minute, r_second, running);
    end
    drive(0, 0, 1, 0, 6'd0, 6'd0);
    step();
    drive(0, 0, 0, 0, 6'd0, 6'd0);
    for (int i = 1; i <= 32; i++) begin
      step();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL basic_model cyc=%0d got=%h want=%h", i, obs(), expv());
      end
      if (i == 1) run1 = running;
      if (sec_tick) ticks++;
      if (expired) begin
        exps++;
        if (exp_at < 0) exp_at = i;
      end
    end
    checks++;
    if (ticks != 3 || exps != 1 || exp_at != 12 || !run1) begin
      errors++;
      $display("FAIL basic_seq ticks=%0d exps=%0d at=%0d run1=%b want 3 1 12 1",
               ticks, exps, exp_at, run1);
    end
    checks++;
    if (r_minute !== 6'd0 || r_second !== 6'd0 || running !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold got=%0d:%0d run=%b want=0:0 run=0",
               r_minute, r_second, running);
    end
  endtask

  task automatic test_borrow();
    int ticks = 0;
    int exp_at = -1;
    drive(1, 0, 0, 0, 6'd1, 6'd0);
    step();
    drive(0, 0, 1, 0, 6'd0, 6'd0);
    step();
    drive(0, 0, 0, 0, 6'd0, 6'd0);
    for (int i = 1; i <= 300 && exp_at < 0; i++) begin
      step();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL borrow_model cyc=%0d got=%h want=%h", i, obs(), expv());
      end
      if (i == 4) begin
        checks++;
        if (r_minute !== 6'd0 || r_second !== 6'd59) begin
          errors++;
          $display("FAIL borrow_first got=%0d:%0d want=0:59", r_minute, r_second);
        end
      end
      if (sec_tick) ticks++;
      if (expired) exp_at = i;
    end
    checks++;
    if (ticks != 60 || exp_at != 240) begin
      errors++;
      $display("FAIL borrow_count ticks=%0d at=%0d want 60 240", ticks, exp_at);
    end
  endtask

  task automatic test_pause();
    drive(1, 0, 0, 0, 6'd0, 6'd5);
    step();
    drive(0, 0, 1, 0, 6'd0, 6'd0);
    step();
    drive(0, 0, 0, 0, 6'd0, 6'd0);
    for (int i = 1; i <= 16; i++) begin
      if (i == 6) drive(0, 0, 0, 1, 6'd0, 6'd0);
      if (i == 7) drive(0, 0, 0, 0, 6'd0, 6'd0);
      step();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL pause_model cyc=%0d got=%h want=%h", i, obs(), expv());
      end
      if (i == 4 || i == 16) begin
        checks++;
        if (r_second !== 6'd4) begin
          errors++;
          $display("FAIL pause_sec cyc=%0d got=%0d want=4", i, r_second);
        end
      end
    end
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL pause_running got=%b want=0", running);
    end
    drive(0, 0, 1, 0, 6'd0, 6'd0);
    for (int i = 0; i <= 2; i++) begin
      step();
      drive(0, 0, 0, 0, 6'd0, 6'd0);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL resume_model cyc=%0d got=%h want=%h", i, obs(), expv());
      end
      checks++;
      if (r_second !== ((i == 2) ? 6'd3 : 6'd4) || running !== 1'b1) begin
        errors++;
        $display("FAIL resume_sec cyc=%0d got=%0d run=%b want=%0d run=1",
                 i, r_second, running, (i == 2) ? 3 : 4);
      end
    end
  endtask

  task automatic test_clamp_priority();
    drive(1, 0, 0, 0, 6'd63, 6'd63);
    step();
    checks++;
    if (r_minute !== 6'd59 || r_second !== 6'd59) begin
      errors++;
      $display("FAIL clamp_max got=%0d:%0d want=59:59", r_minute, r_second);
    end
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, 0, 6'($urandom_range(60, 63)), 6'($urandom_range(0, 63)));
      step();
      checks++;
      if (obs() !== expv() || r_minute !== 6'd59) begin
        errors++;
        $display("FAIL clamp_rand got=%h want=%h", obs(), expv());
      end
    end
    drive(1, 0, 0, 0, 6'd12, 6'd34);
    step();
    drive(1, 1, 1, 0, 6'd7, 6'd7);
    step();
    drive(0, 0, 0, 0, 6'd0, 6'd0);
    checks++;
    if (obs() !== expv() || r_minute !== 6'd0 || r_second !== 6'd0 || running !== 1'b0) begin
      errors++;
      $display("FAIL clear_prio got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_zero_start();
    int exps = 0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, (i == 0 || i == 2), (i == 3), 6'd0, 6'd0);
      step();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL zero_model cyc=%0d got=%h want=%h", i, obs(), expv());
      end
      if (expired) exps++;
      if (i == 0) begin
        checks++;
        if (expired !== 1'b1 || running !== 1'b0) begin
          errors++;
          $display("FAIL zero_expire exp=%b run=%b want exp=1 run=0", expired, running);
        end
      end
    end
    checks++;
    if (exps != 1) begin
      errors++;
      $display("FAIL zero_once pulses=%0d want=1", exps);
    end
    drive(1, 0, 0, 0, 6'd0, 6'd1);
    step();
    drive(0, 0, 1, 0, 6'd0, 6'd0);
    step();
    drive(0, 0, 0, 0, 6'd0, 6'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (obs() !== expv() || expired !== (i == 4)) begin
        errors++;
        $display("FAIL done_exit cyc=%0d got=%h want=%h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0,
            ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'd0,
            6'($urandom_range(0, 63)));
      step();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h want=%h", i, obs(), expv());
      end
    end
    drive(0, 0, 0, 0, 6'd0, 6'd0);
  endtask

  task automatic test_async_reset();
    drive(1, 0, 0, 0, 6'd0, 6'd2);
    step();
    drive(0, 0, 1, 0, 6'd0, 6'd0);
    step();
    drive(0, 0, 0, 0, 6'd0, 6'd0);
    for (int i = 0; i < 6; i++) step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== 15'd0) begin
      errors++;
      $display("FAIL async_reset got=%h want=0", obs());
    end
    model_reset();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) rst_n = 1'b1;
      checks++;
      if (obs() !== 15'd0) begin
        errors++;
        $display("FAIL async_quiet cyc=%0d got=%h want=0", i, obs());
      end
    end
  endtask

`ifdef AUTO_RELOAD_EN
  task automatic test_auto();
    int exps = 0;
    int last = 0;
    drive(1, 0, 0, 0, 6'd0, 6'd2);
    step();
    drive(0, 0, 1, 0, 6'd0, 6'd0);
    step();
    drive(0, 0, 0, 0, 6'd0, 6'd0);
    for (int i = 1; i <= 40; i++) begin
      step();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL auto_model cyc=%0d got=%h want=%h", i, obs(), expv());
      end
      if (expired) begin
        exps++;
        checks++;
        if (i - last != 8 || r_second !== 6'd2 || running !== 1'b1) begin
          errors++;
          $display("FAIL auto_period gap=%0d sec=%0d run=%b want 8 2 1",
                   i - last, r_second, running);
        end
        last = i;
      end
    end
    checks++;
    if (exps != 5) begin
      errors++;
      $display("FAIL auto_count got=%0d want=5", exps);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_pause();
    test_clamp_priority();
    test_zero_start();
    test_random();
    test_async_reset();
`ifdef AUTO_RELOAD_EN
    test_auto();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
